// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: 16-master AHB round-robin arbiter with lock hold and split masking
module ahb_rr_arbiter #(
  parameter int NMASTERS       = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [NMASTERS-1:0] HBUSREQx,
  input  logic [NMASTERS-1:0] HLOCKx,
  input  logic [NMASTERS-1:0] HSPLITx,
  input  logic [1:0]          HTRANS,
  input  logic [1:0]          HRESP,
  input  logic                HREADY,
  output logic [NMASTERS-1:0] HGRANTx,
  output logic [3:0]          HMASTER,
  output logic                HMASTLOCK
);
  localparam int W = $clog2(NMASTERS);
  logic [W-1:0] g_idx, dm, nxt, idx;
  logic [NMASTERS-1:0] mask, split_set, elig;
  logic split, hold, arb, found;
  always_comb begin
    split     = HRESP == 2'b11 && !HREADY;
    split_set = split ? NMASTERS'(1) << dm : '0;
    hold      = (HLOCKx[g_idx] && !mask[g_idx]) || (HTRANS != 2'b00 && HMASTLOCK);
    arb       = split || (HREADY && !hold);
    // the master just split is excluded from the arbitration forced in the same cycle
    elig      = HBUSREQx & ~(mask | split_set);
    nxt       = W'(DEFAULT_MASTER);
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NMASTERS; i++) begin
      idx = g_idx + W'(i);
      if (!found && elig[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      g_idx     <= '0;
      HGRANTx   <= NMASTERS'(1);
      HMASTER   <= '0;
      HMASTLOCK <= 1'b0;
      dm        <= '0;
      mask      <= '0;
    end else begin
      if (arb) begin
        g_idx   <= nxt;
        HGRANTx <= NMASTERS'(1) << nxt;
      end
      if (HREADY) begin
        HMASTER   <= 4'(g_idx);
        HMASTLOCK <= HLOCKx[g_idx];
        dm        <= W'(HMASTER);
      end
      mask <= (mask & ~HSPLITx) | split_set;
    end
  end
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: directed vector table plus hand sequences for the round-robin arbiter
module tb_ahb_rr_arbiter;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [15:0] HBUSREQx, HLOCKx, HSPLITx, HGRANTx;
  logic [1:0]  HTRANS, HRESP;
  logic        HREADY, HMASTLOCK;
  logic [3:0]  HMASTER;
  int checks = 0;
  int errors = 0;

  ahb_rr_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HSPLITx(HSPLITx), .HTRANS(HTRANS), .HRESP(HRESP), .HREADY(HREADY),
    .HGRANTx(HGRANTx), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          n;
    logic        rstn, ready;
    logic [1:0]  trans, resp;
    logic [15:0] req, lock, split;
    logic [15:0] g;
    logic [3:0]  m;
    logic        l;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(int n, logic rstn, logic ready, logic [1:0] trans, logic [1:0] resp,
                             logic [15:0] req, logic [15:0] lock, logic [15:0] split,
                             logic [15:0] g, logic [3:0] m, logic l);
    vec_t r;
    r.n = n; r.rstn = rstn; r.ready = ready; r.trans = trans; r.resp = resp;
    r.req = req; r.lock = lock; r.split = split; r.g = g; r.m = m; r.l = l;
    return r;
  endfunction

  task automatic chk(string name, int row, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic step_check(int row, logic [15:0] g, logic [3:0] m, logic l);
    @(posedge HCLK);
    #1;
    chk("grant", row, HGRANTx, g);
    chk("hmaster", row, 16'(HMASTER), 16'(m));
    chk("hmastlock", row, 16'(HMASTLOCK), 16'(l));
  endtask

  initial begin
    HRESETn = 1'b0; HREADY = 1'b1; HTRANS = 2'b00; HRESP = 2'b00;
    HBUSREQx = '0; HLOCKx = '0; HSPLITx = '0;
    // n rstn rdy trans resp req lock split -> grant master lock
    tbl.push_back(v( 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 0));
    tbl.push_back(v(10, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0028, 16'h0000, 16'h0000, 16'h0008, 0, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0028, 16'h0000, 16'h0000, 16'h0020, 3, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0028, 16'h0000, 16'h0000, 16'h0008, 5, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0028, 16'h0000, 16'h0000, 16'h0020, 3, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0004, 16'h0004, 16'h0000, 16'h0004, 5, 0));
    tbl.push_back(v( 8, 1, 1, 0, 0, 16'hFFFF, 16'h0004, 16'h0000, 16'h0004, 2, 1));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0008, 2, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0010, 16'h0010, 16'h0000, 16'h0010, 3, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0010, 16'h0010, 16'h0000, 16'h0010, 4, 1));
    tbl.push_back(v( 1, 1, 1, 2, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0010, 4, 0));
    tbl.push_back(v( 1, 1, 1, 2, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0020, 4, 0));
    tbl.push_back(v( 5, 1, 0, 0, 0, 16'h0001, 16'h0000, 16'h0000, 16'h0020, 4, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 5, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0010, 0, 0));
    tbl.push_back(v( 2, 1, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0010, 4, 0));
    tbl.push_back(v( 1, 1, 0, 0, 3, 16'h0030, 16'h0000, 16'h0000, 16'h0020, 4, 0));
    tbl.push_back(v( 1, 1, 1, 0, 3, 16'h0030, 16'h0000, 16'h0000, 16'h0020, 5, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0030, 16'h0000, 16'h0000, 16'h0020, 5, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0030, 16'h0000, 16'h0010, 16'h0020, 5, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0030, 16'h0000, 16'h0000, 16'h0010, 5, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 4, 0));
    tbl.push_back(v( 2, 1, 1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 8, 0));
    tbl.push_back(v( 1, 1, 0, 0, 3, 16'h0080, 16'h0080, 16'h0000, 16'h0080, 8, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0001, 7, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0180, 16'h0080, 16'h0000, 16'h0080, 0, 0));
    tbl.push_back(v( 2, 1, 1, 0, 0, 16'h0180, 16'h0080, 16'h0000, 16'h0080, 7, 1));
    tbl.push_back(v( 1, 0, 0, 0, 3, 16'h0180, 16'h0080, 16'h0000, 16'h0001, 0, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 0, 0));
    tbl.push_back(v( 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 16'h0003, 16'h0000, 16'h0000, 16'h0002, 0, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        HRESETn = tbl[r].rstn; HREADY = tbl[r].ready; HTRANS = tbl[r].trans;
        HRESP = tbl[r].resp; HBUSREQx = tbl[r].req; HLOCKx = tbl[r].lock;
        HSPLITx = tbl[r].split;
        step_check(r, tbl[r].g, tbl[r].m, tbl[r].l);
      end
    end

    // stalled bus with changing requests and locks: everything frozen
    HRESETn = 1'b1; HRESP = 2'b00; HTRANS = 2'b00; HSPLITx = '0; HREADY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      HBUSREQx = 16'($urandom);
      HLOCKx   = 16'($urandom);
      step_check(100 + k, 16'h0002, 4'd0, 1'b0);
    end
    HREADY = 1'b1; HBUSREQx = 16'h0001; HLOCKx = '0;
    step_check(105, 16'h0001, 4'd1, 1'b0);
    step_check(106, 16'h0001, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
